// File: rtl/multi_cycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and
// the width helper for the memory wait timer.
package multi_cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_DECODE = 3'd2,
    SEQ_EXEC   = 3'd3,
    SEQ_MEM    = 3'd4,
    SEQ_WB     = 3'd5,
    SEQ_ERR    = 3'd6
  } seq_state_e;

  // Wait counter width: enough bits to hold TIMEOUT, never less than one.
  function automatic int unsigned tmr_width(input int unsigned timeout);
    int unsigned w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/multi_cycle_sequencer_if.sv
// Bus bundle between the sequencer and its memories / pipeline stages.
interface multi_cycle_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] instruction;
  logic             dec_mem_rd;
  logic             dec_mem_wr;
  logic             dec_reg_wr;
  logic [WIDTH-1:0] next_pc;
  logic             dmem_req;
  logic             dmem_wr;
  logic             dmem_ready;
  logic [WIDTH-1:0] dmem_rdata;
  logic [WIDTH-1:0] mem_read_data;
  logic [WIDTH-1:0] PC;
  logic             reg_wr_en;
  logic             retire;
  logic             timeout_err;
  logic [2:0]       state;

  modport master (
    output imem_req, imem_addr, instruction, dmem_req, dmem_wr,
           mem_read_data, PC, reg_wr_en, retire, timeout_err, state,
    input  imem_ready, imem_rdata, dec_mem_rd, dec_mem_wr, dec_reg_wr,
           next_pc, dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, instruction, dmem_req, dmem_wr,
           mem_read_data, PC, reg_wr_en, retire, timeout_err, state,
    output imem_ready, imem_rdata, dec_mem_rd, dec_mem_wr, dec_reg_wr,
           next_pc, dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/multi_cycle_sequencer_wait_timer.sv
// Counts stalled cycles of one memory transaction and flags the cycle in
// which the count would reach TIMEOUT. TIMEOUT=0 disables the flag.
module multi_cycle_sequencer_wait_timer
  import multi_cycle_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);
  localparam int unsigned CW = tmr_width(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear outside a request state, otherwise count stalls.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = '0;
    else if (waiting) cnt_d = cnt_q + CW'(1);
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_cnt;
      assign unused_cnt = ^cnt_q;
      assign expired = 1'b0;
    end else begin : g_on
      // Expires on the stall that would bring the count to TIMEOUT; a ready
      // in that same cycle clears waiting and therefore wins.
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
      assign expired = waiting && !clear && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/multi_cycle_sequencer.sv
// Multi-cycle instruction sequencer: owns PC and IR and steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB with stallable memories.
module multi_cycle_sequencer
  import multi_cycle_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT  = 0
) (
  input logic clk,
  input logic reset,
  multi_cycle_sequencer_if.master bus
);
  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mrd_q, mrd_d;
  logic             in_fetch, in_mem, waiting, expired;
  logic             is_load;

  assign in_fetch = (state_q == SEQ_FETCH);
  assign in_mem   = (state_q == SEQ_MEM);
  assign waiting  = (in_fetch && !bus.imem_ready) || (in_mem && !bus.dmem_ready);
  // Both flags set is treated as a store: nothing is latched.
  assign is_load  = bus.dec_mem_rd && !bus.dec_mem_wr;

  multi_cycle_sequencer_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!(in_fetch || in_mem)),
    .waiting (waiting),
    .expired (expired)
  );

  // State, PC, IR and load-data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mrd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mrd_q   <= mrd_d;
    end
  end

  // Next-state and register updates for each sequencing step.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mrd_d   = mrd_q;
    case (state_q)
      SEQ_IDLE:   state_d = SEQ_FETCH;
      SEQ_FETCH: begin
        if (bus.imem_ready) begin
          ir_d    = bus.imem_rdata;
          state_d = SEQ_DECODE;
        end else if (expired) begin
          state_d = SEQ_ERR;
        end
      end
      SEQ_DECODE: state_d = SEQ_EXEC;
      SEQ_EXEC:   state_d = (bus.dec_mem_rd || bus.dec_mem_wr) ? SEQ_MEM : SEQ_WB;
      SEQ_MEM: begin
        if (bus.dmem_ready) begin
          if (is_load) mrd_d = bus.dmem_rdata;
          state_d = SEQ_WB;
        end else if (expired) begin
          state_d = SEQ_ERR;
        end
      end
      SEQ_WB: begin
        pc_d    = bus.next_pc;
        state_d = SEQ_FETCH;
      end
      SEQ_ERR:    state_d = SEQ_ERR;
      default:    state_d = SEQ_IDLE;
    endcase
  end

  // Moore outputs: strobes decode from state only.
  assign bus.imem_req      = in_fetch;
  assign bus.imem_addr     = pc_q;
  assign bus.dmem_req      = in_mem;
  assign bus.dmem_wr       = in_mem && bus.dec_mem_wr;
  assign bus.reg_wr_en     = (state_q == SEQ_WB) && bus.dec_reg_wr;
  assign bus.retire        = (state_q == SEQ_WB);
  // ERR is only left through reset, which makes the flag sticky.
  assign bus.timeout_err   = (state_q == SEQ_ERR);
  assign bus.instruction   = ir_q;
  assign bus.mem_read_data = mrd_q;
  assign bus.PC            = pc_q;
  assign bus.state         = state_q;

endmodule

// File: doc/multi_cycle_sequencer.md
Name: multi_cycle_sequencer

Overview:
Parametrised multi-cycle successor to the single-cycle datapath's top-level sequencing. It owns the PC and instruction register and steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB. Instruction and data memory use req/ready handshakes, so memory can stall, and a wait timeout traps hung transactions. The existing fetch, control, execute and write-back stages connect around it: the sequencer consumes decoded class bits and next_pc, and gates register write and memory access.

Parameters:
WIDTH, 32, data/address/instruction width
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 0, max wait cycles per memory transaction; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  instruction fetch request
imem_addr  out  WIDTH  fetch address, equals PC
imem_ready  in  1  fetch data valid / handshake complete
imem_rdata  in  WIDTH  fetched instruction
instruction  out  WIDTH  instruction register (IR) contents
dec_mem_rd  in  1  decoded: instruction is a load
dec_mem_wr  in  1  decoded: instruction is a store
dec_reg_wr  in  1  decoded: instruction writes register file
next_pc  in  WIDTH  PC successor from fetch/branch logic
dmem_req  out  1  data memory request
dmem_wr  out  1  data request is a write
dmem_ready  in  1  data handshake complete
dmem_rdata  in  WIDTH  load data
mem_read_data  out  WIDTH  latched load data for write-back
PC  out  WIDTH  current PC register
reg_wr_en  out  1  register-file write strobe (one cycle)
retire  out  1  one-cycle pulse, instruction complete
timeout_err  out  1  sticky error flag
state  out  3  current state encoding, debug

Behaviour:
- Reset (sampled at the rising edge) sets: state=IDLE, PC=RESET_PC, IR=0, mem_read_data=0, timeout_err=0, wait counter=0. All strobes (imem_req, dmem_req, dmem_wr, reg_wr_en, retire) are 0 in IDLE.
- Requests and strobes are Moore outputs decoded from state, with no combinational path from ready inputs.
- IDLE (0): advances to FETCH on the next cycle.
- FETCH (1): imem_req=1, imem_addr=PC. On imem_ready=1, IR<=imem_rdata and advance to DECODE. Ready in the first FETCH cycle is a zero-wait accept.
- DECODE (2): one cycle for register read; advance to EXEC.
- EXEC (3): one cycle. If dec_mem_rd|dec_mem_wr, go to MEM; otherwise go to WB.
- MEM (4): dmem_req=1, dmem_wr=dec_mem_wr. Hold until dmem_ready. On ready, latch mem_read_data<=dmem_rdata if it is a load (a store leaves it unchanged), then go to WB.
- If dec_mem_rd and dec_mem_wr are both set, the access is a write and nothing is latched.
- WB (5): reg_wr_en=dec_reg_wr, retire=1, PC<=next_pc at the edge leaving WB, then go to FETCH.
- ERR (6): all strobes are 0 and timeout_err=1. Only reset exits ERR.
- Latency with zero-wait memory: ALU/branch instructions take 4 cycles (FETCH..WB); loads and stores take 5. Each memory wait cycle adds 1.
- Ready inputs are ignored outside their request state. Ready must not be assumed to stay high.
- Wait counter: clears on entry to FETCH or MEM and increments each cycle that req=1 and ready=0.
- Timeout: with TIMEOUT!=0, if the counter reaches TIMEOUT while still waiting, go to ERR and set timeout_err. Ready arriving in the same cycle wins over the timeout.
- PC arithmetic is modulo 2^WIDTH, so next_pc wrap-around is passed through unchanged.
- Reset mid-transaction abandons the access. The request deasserts the cycle after the reset edge (state=IDLE). No reg_wr_en or retire is issued for the abandoned instruction.

Decomposition:
- Shared package/header: state encodings SEQ_IDLE..SEQ_ERR (3 bits), plus TIMEOUT counter width derived as clog2(TIMEOUT+1), minimum 1.
- One sub-module: wait_timer. Inputs: clk, reset, clear, waiting. Output: expired. Parametrised by TIMEOUT, which ties expired to 0 when TIMEOUT=0.

Test Plan:
- Reset then an ALU instruction, zero-wait imem, dec_reg_wr=1, next_pc=0x4 → imem_req on the cycle after IDLE with addr 0x0; reg_wr_en and retire pulse on cycle 4 after IDLE; PC=0x4 afterward.
- Load with 2-cycle dmem wait, dmem_rdata=0xDEADBEEF → dmem_req held 3 cycles with dmem_wr=0; mem_read_data=0xDEADBEEF in WB; total 7 cycles from FETCH to retire.
- Store with dec_reg_wr=0 → dmem_wr=1 during MEM; no reg_wr_en pulse; mem_read_data unchanged; retire=1.
- TIMEOUT=4, imem_ready stuck at 0 → state=ERR after 4 wait cycles; timeout_err=1 and sticky; strobes=0; reset recovers to IDLE with PC=RESET_PC.
- Ready coincident with the timeout cycle → transaction accepted, no ERR. Stray dmem_ready during FETCH → ignored.
- Reset asserted mid-MEM wait → next cycle state=IDLE, dmem_req=0, no retire. next_pc=0x0 from PC=0xFFFFFFFC → PC wraps to 0x0.
